// File: rtl/acc_flags_unit_if.sv
// rtl/acc_flags_unit_if.sv - control/bus bundle between the instruction controller and the datapath unit
//
// Purpose : groups the control-word enables, opcodes, shared bus and the flag
//           feedback that pass between the controller (master) and the
//           accumulator/flags execution unit (slave).
// Signals : bus_in  - shared data bus value sampled by A/B loads
//           alu_en  - drive ALU result (with a_load: A <= ALU, flags update)
//           a_en    - drive A onto bus_out
//           a_load  - load A
//           b_en    - drive B onto bus_out
//           b_load  - load B from bus_in
//           alu_op  - 0 ADD 1 ADDC 2 SUB 3 SUBB 4 MOD 5 AND 6 OR 7 XOR
//           a_op    - 0 none 1 INC 2 DEC 3 SHL 4 SHR 5 NOT 6 COM 7 none
//           bus_out - value driven by the unit (0 when idle)
//           bus_oe  - any of alu_en/a_en/b_en set
//           flags   - registered {S, C, Z}
//           a_value - current A register
interface acc_flags_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] bus_in;
  logic             alu_en;
  logic             a_en;
  logic             a_load;
  logic             b_en;
  logic             b_load;
  logic [2:0]       alu_op;
  logic [2:0]       a_op;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic [2:0]       flags;
  logic [WIDTH-1:0] a_value;

  modport master (
    output bus_in, alu_en, a_en, a_load, b_en, b_load, alu_op, a_op,
    input  bus_out, bus_oe, flags, a_value
  );

  modport slave (
    input  bus_in, alu_en, a_en, a_load, b_en, b_load, alu_op, a_op,
    output bus_out, bus_oe, flags, a_value
  );
endinterface

// File: rtl/acc_flags_unit.sv
// rtl/acc_flags_unit.sv - accumulator, B register, 8-function ALU and Z/C/S flags
//
// Purpose : execution unit downstream of the instruction controller. Holds A,
//           B and the flags register, computes ALU and A-op results, and
//           drives A, B or the ALU result onto the shared bus.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset (A, B, flags cleared)
//           dp  - acc_flags_unit_if.slave control/bus bundle
module acc_flags_unit #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  acc_flags_unit_if.slave dp
);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_ADDC = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_SUBB = 3'd3;
  localparam logic [2:0] ALU_MOD  = 3'd4;
  localparam logic [2:0] ALU_AND  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  localparam logic [2:0] AOP_INC = 3'd1;
  localparam logic [2:0] AOP_DEC = 3'd2;
  localparam logic [2:0] AOP_SHL = 3'd3;
  localparam logic [2:0] AOP_SHR = 3'd4;
  localparam logic [2:0] AOP_NOT = 3'd5;
  localparam logic [2:0] AOP_COM = 3'd6;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       flags_q, flags_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   alu_wide;
  logic [WIDTH:0]   ext_a, ext_b, ext_cin;

  logic [WIDTH-1:0] aop_res;
  logic             aop_c;
  logic             aop_valid;

  // Carry-in is the registered C flag.
  assign ext_a   = {1'b0, a_q};
  assign ext_b   = {1'b0, b_q};
  assign ext_cin = {{WIDTH{1'b0}}, flags_q[1]};

  // ALU. Arithmetic runs one bit wider so the top bit is carry-out for
  // additions and the borrow (result went negative) for subtractions.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (dp.alu_op)
      ALU_ADD: begin
        alu_wide = ext_a + ext_b;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      ALU_ADDC: begin
        alu_wide = ext_a + ext_b + ext_cin;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      ALU_SUB: begin
        alu_wide = ext_a - ext_b;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      ALU_SUBB: begin
        // A - B - Cin bottoms out at -2^WIDTH, which still fits WIDTH+1 bits.
        alu_wide = ext_a - ext_b - ext_cin;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      ALU_MOD: begin
        // Divide-by-zero leaves the dividend untouched.
        alu_res = (b_q == ZERO) ? a_q : (a_q % b_q);
      end
      ALU_AND: alu_res = a_q & b_q;
      ALU_OR:  alu_res = a_q | b_q;
      ALU_XOR: alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  // Single-operand A operations; code 0 and the reserved code 7 are no-ops.
  always_comb begin
    aop_res   = a_q;
    aop_c     = 1'b0;
    aop_valid = 1'b1;
    case (dp.a_op)
      AOP_INC: begin
        aop_res = a_q + ONE;
        aop_c   = &a_q;
      end
      AOP_DEC: begin
        aop_res = a_q - ONE;
        aop_c   = ~|a_q;
      end
      AOP_SHL: begin
        aop_res = {a_q[WIDTH-2:0], 1'b0};
        aop_c   = a_q[WIDTH-1];
      end
      AOP_SHR: begin
        aop_res = {1'b0, a_q[WIDTH-1:1]};
        aop_c   = a_q[0];
      end
      AOP_NOT: aop_res = ~a_q;
      AOP_COM: begin
        aop_res = ZERO - a_q;
        aop_c   = |a_q;
      end
      default: aop_valid = 1'b0;
    endcase
  end

  // Next-state: ALU write-back beats a plain bus load, which beats an A-op.
  // a_op is ignored whenever a_load is set. B loads independently.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    flags_d = flags_q;
    if (dp.a_load && dp.alu_en) begin
      a_d     = alu_res;
      flags_d = {alu_res[WIDTH-1], alu_c, (alu_res == ZERO)};
    end else if (dp.a_load) begin
      a_d = dp.bus_in;
    end else if (aop_valid) begin
      a_d     = aop_res;
      flags_d = {aop_res[WIDTH-1], aop_c, (aop_res == ZERO)};
    end
    if (dp.b_load) begin
      b_d = dp.bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= 3'b000;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
    end
  end

  // Bus drive priority alu_en > a_en > b_en; multiple enables are a
  // controller bug but the priority still resolves them deterministically.
  always_comb begin
    dp.bus_out = '0;
    if (dp.alu_en) begin
      dp.bus_out = alu_res;
    end else if (dp.a_en) begin
      dp.bus_out = a_q;
    end else if (dp.b_en) begin
      dp.bus_out = b_q;
    end
  end

  assign dp.bus_oe  = dp.alu_en | dp.a_en | dp.b_en;
  assign dp.flags   = flags_q;
  assign dp.a_value = a_q;

endmodule

// File: tb/tb_acc_flags_unit.sv
// tb/tb_acc_flags_unit.sv - randomized and directed self-checking bench for acc_flags_unit
module tb_acc_flags_unit;

  localparam int W = 16;
  localparam int M = 65536;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  // reference state: plain integers
  int ma, mb, mz, mc, ms;

  acc_flags_unit_if #(.WIDTH(W)) dp ();

  acc_flags_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .dp (dp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                  output int r, output int c);
    int t;
    c = 0;
    case (op)
      0: begin t = a + b;       r = t % M; c = (t >= M) ? 1 : 0; end
      1: begin t = a + b + cin; r = t % M; c = (t >= M) ? 1 : 0; end
      2: begin r = (a - b + M) % M;            c = (a < b) ? 1 : 0; end
      3: begin r = (a - b - cin + 2 * M) % M;  c = (a < b + cin) ? 1 : 0; end
      4: r = (b == 0) ? a : a % b;
      5: r = a & b;
      6: r = a | b;
      default: r = a ^ b;
    endcase
  endfunction

  function automatic void ref_aop(input int op, input int a, output int r, output int c,
                                  output int valid);
    valid = 1;
    c = 0;
    r = a;
    case (op)
      1: begin r = (a + 1) % M;     c = (a == M - 1) ? 1 : 0; end
      2: begin r = (a + M - 1) % M; c = (a == 0) ? 1 : 0; end
      3: begin r = (a * 2) % M;     c = (a >= M / 2) ? 1 : 0; end
      4: begin r = a / 2;           c = a % 2; end
      5: r = M - 1 - a;
      6: begin r = (M - a) % M;     c = (a != 0) ? 1 : 0; end
      default: valid = 0;
    endcase
  endfunction

  function automatic int exp_flags();
    return ms * 4 + mc * 2 + mz;
  endfunction

  // One clock: checks the combinational bus before the edge, advances the
  // model at the edge, then checks A and flags shortly after.
  task automatic drive(input bit r, input int bi, input bit ae, input bit aen, input bit al,
                       input bit ben, input bit bl, input int aluop, input int aop,
                       output int bo, output int oe);
    int ar, ac, orr, oc, ov, eb;
    rst       = r;
    dp.bus_in = bi[W-1:0];
    dp.alu_en = ae;
    dp.a_en   = aen;
    dp.a_load = al;
    dp.b_en   = ben;
    dp.b_load = bl;
    dp.alu_op = aluop[2:0];
    dp.a_op   = aop[2:0];
    #1;
    ref_alu(aluop, ma, mb, mc, ar, ac);
    eb = ae ? ar : (aen ? ma : (ben ? mb : 0));
    check("bus_out", 32'(dp.bus_out), eb);
    check("bus_oe", 32'(dp.bus_oe), 32'(ae | aen | ben));
    bo = int'(dp.bus_out);
    oe = int'(dp.bus_oe);
    @(posedge clk);
    if (r) begin
      ma = 0; mb = 0; mz = 0; mc = 0; ms = 0;
    end else begin
      ref_aop(aop, ma, orr, oc, ov);
      if (al && ae) begin
        ma = ar; mc = ac; mz = (ar == 0); ms = (ar >= M / 2);
      end else if (al) begin
        ma = bi % M;
      end else if (ov != 0) begin
        ma = orr; mc = oc; mz = (orr == 0); ms = (orr >= M / 2);
      end
      if (bl) mb = bi % M;
    end
    #1;
    check("a_value", 32'(dp.a_value), ma);
    check("flags", 32'(dp.flags), exp_flags());
    @(negedge clk);
  endtask

  int bo, oe;

  task automatic ld_a(input int v);
    drive(0, v, 0, 0, 1, 0, 0, 0, 0, bo, oe);
  endtask
  task automatic ld_b(input int v);
    drive(0, v, 0, 0, 0, 0, 1, 0, 0, bo, oe);
  endtask
  task automatic alu(input int op);
    drive(0, 0, 1, 0, 1, 0, 0, op, 0, bo, oe);
  endtask
  task automatic aop(input int op);
    drive(0, 0, 0, 0, 0, 0, 0, 0, op, bo, oe);
  endtask
  task automatic expect_af(input string tag, input int a, input int f);
    check({tag, "_a"}, 32'(dp.a_value), a);
    check({tag, "_flags"}, 32'(dp.flags), f);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    ma = 0; mb = 0; mz = 0; mc = 0; ms = 0;
    rst = 1'b1;
    dp.bus_in = '0; dp.alu_en = 0; dp.a_en = 0; dp.a_load = 0;
    dp.b_en = 0; dp.b_load = 0; dp.alu_op = '0; dp.a_op = '0;
    @(negedge clk);

    // reset: plain, then with random activity on every input
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, bo, oe);
    ld_a(16'h5A5A); ld_b(16'hA5A5); aop(1);
    drive(1, $urandom_range(0, M - 1), 1, 1, 1, 1, 1, $urandom_range(0, 7), $urandom_range(1, 6), bo, oe);
    expect_af("rst", 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, bo, oe);
    check("rst_idle_bus", bo, 0);
    check("rst_idle_oe", oe, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, bo, oe);
    check("rst_b", bo, 0);

    // ADD carry, then ADDC consuming Cin
    ld_b(16'h0001); ld_a(16'hFFFF);
    alu(0); expect_af("add", 16'h0000, 3'b011);
    alu(1); expect_af("addc", 16'h0002, 3'b000);

    // SUB borrow, then SUBB
    ld_a(16'h0005); ld_b(16'h0007);
    alu(2); expect_af("sub", 16'hFFFE, 3'b110);
    ld_b(16'h0000);
    alu(3); expect_af("subb", 16'hFFFD, 3'b100);

    // modulo, including divide-by-zero
    ld_a(16'h0017); ld_b(16'h0005);
    alu(4); expect_af("mod", 16'h0003, 3'b000);
    ld_b(16'h0000);
    alu(4); expect_af("mod0", 16'h0003, 3'b000);

    // A-ops
    ld_a(16'h8001);
    aop(3); expect_af("shl", 16'h0002, 3'b010);
    aop(4); expect_af("shr", 16'h0001, 3'b000);
    aop(2); expect_af("dec1", 16'h0000, 3'b001);
    aop(2); expect_af("dec0", 16'hFFFF, 3'b110);
    ld_a(16'h0001);
    aop(6); expect_af("com", 16'hFFFF, 3'b110);
    aop(1); expect_af("inc", 16'h0000, 3'b011);

    // a_load overrides a_op; flags untouched
    drive(0, 16'h1234, 0, 0, 1, 0, 0, 0, 1, bo, oe);
    expect_af("load_pri", 16'h1234, 3'b011);

    // all three enables: ALU result wins the bus
    ld_b(16'h0003);
    drive(0, 0, 1, 1, 0, 1, 0, 0, 0, bo, oe);
    check("bus_pri", bo, 16'h1237);
    check("bus_pri_oe", oe, 1);

    // MOVBA: B on the bus, A loads it
    drive(0, 16'h0003, 0, 0, 1, 1, 0, 0, 0, bo, oe);
    check("movba_bus", bo, 16'h0003);
    expect_af("movba", 16'h0003, 3'b011);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int v;
      case ($urandom_range(0, 4))
        0: v = 0;
        1: v = M - 1;
        2: v = $urandom_range(0, 15);
        default: v = $urandom_range(0, M - 1);
      endcase
      drive(($urandom_range(0, 49) == 0), v,
            $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7), $urandom_range(0, 7), bo, oe);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
